// File: rtl/mips_pkg.sv
// Shared widths and memory-stage FSM encoding for the MIPS pipeline.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_pkg;

  localparam int XLEN  = 32;
  localparam int REG_W = 5;

  // IDLE: ready for a new access; WAIT: request outstanding;
  // HELD: access finished but the pipeline has not moved yet.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HELD = 2'd2
  } ms_state_e;

endpackage

// File: rtl/dm_store_buf.sv
// One-entry posted store buffer between the memory stage and the data-memory port.
// Latency: a pushed store is presented on the port the cycle after the push.
// Backpressure: full stays high until the memory acknowledges the buffered write.
module dm_store_buf
  import mips_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic [XLEN-1:0] push_addr,
  input  logic [XLEN-1:0] push_dat,
  input  logic            ack,
  output logic            full,
  output logic [XLEN-1:0] addr,
  output logic [XLEN-1:0] dat
);

  logic            full_q, full_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] dat_q,  dat_d;

  // Fill on push (only offered while empty), empty when the write is acknowledged.
  always_comb begin
    full_d = full_q;
    addr_d = addr_q;
    dat_d  = dat_q;
    if (push) begin
      full_d = 1'b1;
      addr_d = push_addr;
      dat_d  = push_dat;
    end else if (full_q && ack) begin
      full_d = 1'b0;
    end
  end

  // Entry storage; contents only meaningful while full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_q <= 1'b0;
      addr_q <= '0;
      dat_q  <= '0;
    end else begin
      full_q <= full_d;
      addr_q <= addr_d;
      dat_q  <= dat_d;
    end
  end

  assign full = full_q;
  assign addr = addr_q;
  assign dat  = dat_q;

endmodule

// File: rtl/memory_stage.sv
// MIPS memory stage: load/store over a req/ack data-memory port, registers ME/WB.
// Latency: one edge for ALU ops and zero-wait accesses; N extra cycles for N-cycle memory.
// Backpressure: Stall_ME while an access is outstanding; AnyStall freezes ME/WB.
// Optional: DM_STORE_BUFFER_EN adds a one-entry posted store buffer.
module memory_stage
  import mips_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             AnyStall,
  input  logic [XLEN-1:0]  Result_EX,
  input  logic [XLEN-1:0]  WrDat_EX,
  input  logic [REG_W-1:0] WriteReg_EX,
  input  logic             RegWrite_EX,
  input  logic             MemToReg_EX,
  input  logic             MemWrite_EX,
  output logic             DmReq,
  output logic             DmWe,
  output logic [XLEN-1:0]  DmAddr,
  output logic [XLEN-1:0]  DmWrDat,
  input  logic             DmAck,
  input  logic [XLEN-1:0]  DmRdDat,
  output logic [XLEN-1:0]  ResultRdDat_ME,
  output logic [REG_W-1:0] WriteReg_ME,
  output logic             RegWrite_ME,
  output logic             Stall_ME
);

  ms_state_e        state_q, state_d;
  logic [XLEN-1:0]  hold_q, hold_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic [REG_W-1:0] wreg_q, wreg_d;
  logic             regwr_q, regwr_d;

  logic             memop;
  logic             held;
  logic             issue;   // this instruction drives its own request on the port
  logic             done;    // this instruction's memory work completes this cycle
  logic             advance;
  logic [XLEN-1:0]  loaddata;

  assign memop = MemToReg_EX | MemWrite_EX;
  assign held  = (state_q == HELD);

`ifdef DM_STORE_BUFFER_EN
  logic            is_ld;
  logic            is_st;
  logic            sb_full;
  logic            sb_push;
  logic            sb_ack;
  logic [XLEN-1:0] sb_addr;
  logic [XLEN-1:0] sb_dat;

  assign is_st   = MemWrite_EX;
  assign is_ld   = MemToReg_EX & ~MemWrite_EX;
  // A store is posted only from IDLE so an instruction parked in HELD is never re-posted.
  assign sb_push = is_st & ~sb_full & (state_q == IDLE);
  // Loads wait behind a buffered store so the port sees accesses in program order.
  assign issue   = is_ld & ~sb_full & ~held;
  assign sb_ack  = sb_full & DmAck;
  assign done    = (issue & DmAck) | sb_push;

  dm_store_buf u_sb (
    .clk       (clk),
    .reset     (reset),
    .push      (sb_push),
    .push_addr (Result_EX),
    .push_dat  (WrDat_EX),
    .ack       (sb_ack),
    .full      (sb_full),
    .addr      (sb_addr),
    .dat       (sb_dat)
  );

  // Port is owned by the draining buffer first, otherwise by the load in EX.
  always_comb begin
    DmReq   = ~reset & (sb_full | issue);
    DmWe    = sb_full;
    DmAddr  = sb_full ? sb_addr : Result_EX;
    DmWrDat = sb_full ? sb_dat  : WrDat_EX;
  end
`else
  assign issue = memop & ~held;
  assign done  = issue & DmAck;

  // Request fields come straight from EX, which is frozen while we stall.
  always_comb begin
    DmReq   = ~reset & issue;
    DmWe    = MemWrite_EX;
    DmAddr  = Result_EX;
    DmWrDat = WrDat_EX;
  end
`endif

  assign Stall_ME = memop & ~held & ~done;
  assign advance  = ~AnyStall & ~Stall_ME;
  assign loaddata = held ? hold_q : DmRdDat;

  // Next state: park completed accesses in HELD while the pipeline is frozen.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE, WAIT: begin
        if (done && !advance) begin
          state_d = HELD;
          hold_d  = DmRdDat;
        end else if (done) begin
          state_d = IDLE;
        end else if (issue) begin
          state_d = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      HELD: begin
        if (advance) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Access FSM and captured load data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // ME/WB register inputs: load only on advance, otherwise hold.
  always_comb begin
    result_d = result_q;
    wreg_d   = wreg_q;
    regwr_d  = regwr_q;
    if (advance) begin
      result_d = MemToReg_EX ? loaddata : Result_EX;
      wreg_d   = WriteReg_EX;
      regwr_d  = RegWrite_EX;
    end
  end

  // ME/WB pipeline register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q <= '0;
      wreg_q   <= '0;
      regwr_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      wreg_q   <= wreg_d;
      regwr_q  <= regwr_d;
    end
  end

  assign ResultRdDat_ME = result_q;
  assign WriteReg_ME    = wreg_q;
  assign RegWrite_ME    = regwr_q;

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboarded random bench for memory_stage with a variable-latency memory responder.
// Latency: n/a.
// Backpressure: random AnyStall plus directed stall patterns.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        AnyStall;
  logic [31:0] Result_EX, WrDat_EX;
  logic [4:0]  WriteReg_EX;
  logic        RegWrite_EX, MemToReg_EX, MemWrite_EX;
  logic        DmReq, DmWe, DmAck;
  logic [31:0] DmAddr, DmWrDat, DmRdDat;
  logic [31:0] ResultRdDat_ME;
  logic [4:0]  WriteReg_ME;
  logic        RegWrite_ME, Stall_ME;

  always #5 clk = ~clk;

  memory_stage dut (
    .clk            (clk),
    .reset          (reset),
    .AnyStall       (AnyStall),
    .Result_EX      (Result_EX),
    .WrDat_EX       (WrDat_EX),
    .WriteReg_EX    (WriteReg_EX),
    .RegWrite_EX    (RegWrite_EX),
    .MemToReg_EX    (MemToReg_EX),
    .MemWrite_EX    (MemWrite_EX),
    .DmReq          (DmReq),
    .DmWe           (DmWe),
    .DmAddr         (DmAddr),
    .DmWrDat        (DmWrDat),
    .DmAck          (DmAck),
    .DmRdDat        (DmRdDat),
    .ResultRdDat_ME (ResultRdDat_ME),
    .WriteReg_ME    (WriteReg_ME),
    .RegWrite_ME    (RegWrite_ME),
    .Stall_ME       (Stall_ME)
  );

  typedef struct { logic [31:0] res; logic [4:0] wreg; logic rw; } wb_t;
  typedef struct { logic we; logic [31:0] addr; logic [31:0] dat; } mreq_t;

  wb_t         sbq[$];
  mreq_t       memq[$];
  logic [31:0] ref_mem [logic [31:0]];   // architectural memory in program order
  logic [31:0] rsp_mem [logic [31:0]];   // memory as seen by the responder

  int          n_vec = 0;
  int          n_miss = 0;
  int          lat_sel = 0;    // <0: random latency 0..3
  int          as_mode = 0;    // 0: no AnyStall, 1: random, 2: as_pat
  logic [15:0] as_pat = '0;
  int          ack_cnt = 0;
  int          memop_cnt = 0;
  logic        instr_vld = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory responder: acks after the selected latency, checks each request against program order.
  initial begin
    bit          busy;
    int          cnt;
    mreq_t       s, e;
    busy    = 0;
    cnt     = 0;
    DmAck   = 1'b0;
    DmRdDat = '0;
    forever begin
      @(posedge clk);
      #2;
      if (DmReq && !reset) begin
        if (!busy) begin
          busy   = 1;
          cnt    = (lat_sel < 0) ? $urandom_range(0, 3) : lat_sel;
          s.we   = DmWe;
          s.addr = DmAddr;
          s.dat  = DmWrDat;
        end
        if (cnt == 0) begin
          DmAck = 1'b1;
          busy  = 0;
          ack_cnt++;
          if (DmWe) begin
            rsp_mem[DmAddr] = DmWrDat;
            DmRdDat = $urandom;
          end else begin
            DmRdDat = rsp_mem.exists(DmAddr) ? rsp_mem[DmAddr] : 32'h0;
          end
          chk("req_addr_stable", DmAddr, s.addr);
          chk("req_we_stable", DmWe, s.we);
          if (memq.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL req_unexpected: got access to 0x%08h, expected none", DmAddr);
          end else begin
            e = memq.pop_front();
            chk("req_we", DmWe, e.we);
            chk("req_addr", DmAddr, e.addr);
            if (e.we) chk("req_wdat", DmWrDat, e.dat);
          end
        end else begin
          cnt--;
          DmAck   = 1'b0;
          DmRdDat = $urandom;
        end
      end else begin
        busy    = 0;
        DmAck   = 1'b0;
        DmRdDat = $urandom;
      end
    end
  end

  // Monitor: after every edge on which the stage advanced, ME/WB must match the next expectation.
  initial begin
    bit  pend;
    wb_t e;
    pend = 0;
    forever begin
      @(negedge clk);
      if (pend) begin
        if (sbq.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL wb_unexpected: got result 0x%08h, expected no write-back", ResultRdDat_ME);
        end else begin
          e = sbq.pop_front();
          chk("wb_result", ResultRdDat_ME, e.res);
          chk("wb_wreg", WriteReg_ME, e.wreg);
          chk("wb_regwrite", RegWrite_ME, e.rw);
        end
      end
      pend = instr_vld && !reset && !AnyStall && !Stall_ME;
    end
  end

  // Present one instruction in EX (kind 0=ALU, 1=load, 2=store) and hold it until consumed.
  // Called and returns at posedge+1.
  task automatic do_instr(input int kind, input logic [31:0] addr, input logic [31:0] wdat,
                          input logic [4:0] wreg, input logic rw,
                          output int stall_cnt, output int req_cnt);
    wb_t   w;
    mreq_t m;
    int    cyc;
    logic  adv;
    stall_cnt = 0;
    req_cnt   = 0;
    w.wreg = wreg;
    w.rw   = rw;
    if (kind == 1) w.res = ref_mem.exists(addr) ? ref_mem[addr] : 32'h0;
    else           w.res = addr;
    sbq.push_back(w);
    if (kind != 0) begin
      m.we   = (kind == 2);
      m.addr = addr;
      m.dat  = wdat;
      memq.push_back(m);
      memop_cnt++;
    end
    if (kind == 2) ref_mem[addr] = wdat;

    Result_EX   = addr;
    WrDat_EX    = wdat;
    WriteReg_EX = wreg;
    RegWrite_EX = rw;
    MemToReg_EX = (kind == 1);
    MemWrite_EX = (kind == 2);
    instr_vld   = 1'b1;
    cyc = 0;
    forever begin
      case (as_mode)
        0:       AnyStall = 1'b0;
        1:       AnyStall = ($urandom_range(0, 3) == 0);
        default: AnyStall = (cyc < 16) ? as_pat[cyc] : 1'b0;
      endcase
      @(negedge clk);
      if (Stall_ME) stall_cnt++;
      if (DmReq)    req_cnt++;
      adv = !AnyStall && !Stall_ME;
      @(posedge clk);
      #1;
      if (adv) break;
      cyc++;
      if (cyc > 100) begin
        n_vec++;
        n_miss++;
        $display("FAIL instr_timeout: got no advance in %0d cycles, expected advance", cyc);
        break;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion by 500us, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sc, rc, a0, kind;
    logic [31:0] addr;
    reset       = 1'b1;
    AnyStall    = 1'b1;
    Result_EX   = '0;
    WrDat_EX    = '0;
    WriteReg_EX = '0;
    RegWrite_EX = 1'b0;
    MemToReg_EX = 1'b1;
    MemWrite_EX = 1'b0;
    #2;
    chk("dmreq_in_reset", DmReq, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    MemToReg_EX = 1'b0;
    reset       = 1'b0;
    @(negedge clk);
    chk("rst_result", ResultRdDat_ME, 32'h0);
    chk("rst_wreg", WriteReg_ME, 5'd0);
    chk("rst_regwrite", RegWrite_ME, 1'b0);
    chk("rst_dmreq", DmReq, 1'b0);
    chk("rst_stall", Stall_ME, 1'b0);
    @(posedge clk);
    #1;

    // Zero-wait load.
    ref_mem[32'h100] = 32'hDEADBEEF;
    rsp_mem[32'h100] = 32'hDEADBEEF;
    lat_sel = 0;
    as_mode = 0;
    do_instr(1, 32'h100, 32'h0, 5'd3, 1'b1, sc, rc);
    chk("zw_stall_cycles", sc, 0);
    chk("zw_req_cycles", rc, 1);

    // Three-cycle load.
    ref_mem[32'h104] = 32'h0BADF00D;
    rsp_mem[32'h104] = 32'h0BADF00D;
    lat_sel = 3;
    a0 = ack_cnt;
    do_instr(1, 32'h104, 32'h0, 5'd4, 1'b1, sc, rc);
    chk("lat3_stall_cycles", sc, 3);
    chk("lat3_req_cycles", rc, 4);
    chk("lat3_acks", ack_cnt - a0, 1);

    // Ack lands while AnyStall is high, then two more frozen cycles.
    ref_mem[32'h108] = 32'h13572468;
    rsp_mem[32'h108] = 32'h13572468;
    lat_sel = 1;
    as_mode = 2;
    as_pat  = 16'b0000_0000_0000_1110;
    a0 = ack_cnt;
    do_instr(1, 32'h108, 32'h0, 5'd5, 1'b1, sc, rc);
    chk("held_stall_cycles", sc, 1);
    chk("held_req_cycles", rc, 2);
    chk("held_acks", ack_cnt - a0, 1);

    // ALU pass-through.
    as_mode = 0;
    lat_sel = 0;
    do_instr(0, 32'h1234, $urandom, 5'd7, 1'b1, sc, rc);
    chk("alu_stall_cycles", sc, 0);
    chk("alu_req_cycles", rc, 0);

    // Store then immediate load of the same address, memory latency 2.
    lat_sel = 2;
    do_instr(2, 32'h40, 32'hCAFEF00D, 5'd0, 1'b0, sc, rc);
`ifdef DM_STORE_BUFFER_EN
    chk("sb_store_stall_cycles", sc, 0);
`else
    chk("store_stall_cycles", sc, 2);
`endif
    do_instr(1, 32'h40, 32'h0, 5'd9, 1'b1, sc, rc);
`ifdef DM_STORE_BUFFER_EN
    chk("sb_load_stall_cycles", sc, 5);
`else
    chk("load_after_store_stall_cycles", sc, 2);
`endif

    // Random instruction mix with random latency and random global stalls.
    lat_sel = -1;
    as_mode = 1;
    for (int i = 0; i < 200; i++) begin
      kind = $urandom_range(0, 2);
      addr = 32'h40 + 32'(4 * $urandom_range(0, 3));
      if (kind == 0) addr = $urandom;
      do_instr(kind, addr, $urandom, 5'($urandom), (kind == 2) ? 1'b0 : 1'($urandom), sc, rc);
    end

    // Bubble and drain.
    MemToReg_EX = 1'b0;
    MemWrite_EX = 1'b0;
    instr_vld   = 1'b0;
    AnyStall    = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("total_acks", ack_cnt, memop_cnt);
    chk("memq_empty", memq.size(), 0);
    chk("sbq_empty", sbq.size(), 0);

    // Reset in the middle of a slow load.
    lat_sel     = 10;
    AnyStall    = 1'b0;
    Result_EX   = 32'h44;
    WriteReg_EX = 5'd11;
    RegWrite_EX = 1'b1;
    MemToReg_EX = 1'b1;
    @(negedge clk);
    chk("midrst_req_before", DmReq, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_dmreq_drop", DmReq, 1'b0);
    MemToReg_EX = 1'b0;
    @(negedge clk);
    chk("midrst_result", ResultRdDat_ME, 32'h0);
    chk("midrst_regwrite", RegWrite_ME, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
